// File: rtl/wb_mux_n_if.sv
// Wishbone bundle between one master, the wb_mux_n decoder and its NUM_SLAVES peripherals.
// The slave modport is the mux's view; the master modport is the surrounding master plus peripherals.
interface wb_mux_n_if #(
  parameter int NUM_SLAVES = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int SEL_WIDTH  = DATA_WIDTH / 8
);
  // upstream master side
  logic [ADDR_WIDTH-1:0]            wbm_adr_i;
  logic [DATA_WIDTH-1:0]            wbm_dat_i;
  logic [DATA_WIDTH-1:0]            wbm_dat_o;
  logic                             wbm_we_i;
  logic [SEL_WIDTH-1:0]             wbm_sel_i;
  logic                             wbm_stb_i;
  logic                             wbm_cyc_i;
  logic                             wbm_ack_o;
  logic                             wbm_err_o;

  // downstream peripheral side
  logic [ADDR_WIDTH-1:0]            wbs_adr_o;
  logic [DATA_WIDTH-1:0]            wbs_dat_o;
  logic                             wbs_we_o;
  logic [SEL_WIDTH-1:0]             wbs_sel_o;
  logic [NUM_SLAVES-1:0]            wbs_stb_o;
  logic [NUM_SLAVES-1:0]            wbs_cyc_o;
  logic [NUM_SLAVES*DATA_WIDTH-1:0] wbs_dat_i;
  logic [NUM_SLAVES-1:0]            wbs_ack_i;
  logic [NUM_SLAVES-1:0]            wbs_err_i;

  modport slave (
    input  wbm_adr_i, wbm_dat_i, wbm_we_i, wbm_sel_i, wbm_stb_i, wbm_cyc_i,
    output wbm_dat_o, wbm_ack_o, wbm_err_o,
    output wbs_adr_o, wbs_dat_o, wbs_we_o, wbs_sel_o, wbs_stb_o, wbs_cyc_o,
    input  wbs_dat_i, wbs_ack_i, wbs_err_i
  );

  modport master (
    output wbm_adr_i, wbm_dat_i, wbm_we_i, wbm_sel_i, wbm_stb_i, wbm_cyc_i,
    input  wbm_dat_o, wbm_ack_o, wbm_err_o,
    input  wbs_adr_o, wbs_dat_o, wbs_we_o, wbs_sel_o, wbs_stb_o, wbs_cyc_o,
    output wbs_dat_i, wbs_ack_i, wbs_err_i
  );
endinterface

// File: rtl/wb_mux_n.sv
// N-port Wishbone address decoder/mux with registered select, decode error, cycle abort and status.
// Optional bus timeout is enabled by defining WB_MUX_TIMEOUT_EN.
module wb_mux_n #(
  parameter int NUM_SLAVES     = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int SEL_WIDTH      = DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                                             i_clk,
  input  logic                                             i_rst_n,
  wb_mux_n_if.slave                                        bus,
  input  logic [NUM_SLAVES*ADDR_WIDTH-1:0]                 i_slv_addr,
  input  logic [NUM_SLAVES*ADDR_WIDTH-1:0]                 i_slv_mask,
  output logic                                             o_busy,
  output logic [((NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1)-1:0] o_sel_idx,
  output logic                                             o_timeout
);

  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  if (NUM_SLAVES < 1 || NUM_SLAVES > 16) begin : g_bad_num_slaves
    $error("wb_mux_n: NUM_SLAVES must be in 1..16");
  end
  if (SEL_WIDTH != DATA_WIDTH / 8) begin : g_bad_sel_width
    $error("wb_mux_n: SEL_WIDTH must equal DATA_WIDTH/8");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("wb_mux_n: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t                state_q,  state_d;
  logic [IDX_W-1:0]      idx_q,    idx_d;
  logic [ADDR_WIDTH-1:0] adr_q,    adr_d;
  logic [DATA_WIDTH-1:0] wdat_q,   wdat_d;
  logic                  we_q,     we_d;
  logic [SEL_WIDTH-1:0]  sel_q,    sel_d;
  logic [NUM_SLAVES-1:0] stb_q,    stb_d;
  logic                  ack_q,    ack_d;
  logic                  err_q,    err_d;
  logic [DATA_WIDTH-1:0] rdata_q,  rdata_d;

`ifdef WB_MUX_TIMEOUT_EN
  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
`endif

  // Address decode: scanning from the top down leaves the lowest matching index in place.
  logic                  hit;
  logic [IDX_W-1:0]      hit_idx;
  logic [NUM_SLAVES-1:0] hit_onehot;

  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
    hit        = 1'b0;
    hit_idx    = '0;
    hit_onehot = '0;
    for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
      if (((bus.wbm_adr_i ^ i_slv_addr[k*ADDR_WIDTH +: ADDR_WIDTH])
           & i_slv_mask[k*ADDR_WIDTH +: ADDR_WIDTH]) == '0) begin
        hit           = 1'b1;
        hit_idx       = IDX_W'(k);
        hit_onehot    = '0;
        hit_onehot[k] = 1'b1;
      end
    end
  end

  // Response of the currently selected slave; everything from other ports is ignored.
  logic                  ack_sel;
  logic                  err_sel;
  logic [DATA_WIDTH-1:0] rdata_sel;

  always_comb begin
    ack_sel   = 1'b0;
    err_sel   = 1'b0;
    rdata_sel = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (idx_q == IDX_W'(k)) begin
        ack_sel   = bus.wbs_ack_i[k];
        err_sel   = bus.wbs_err_i[k];
        rdata_sel = bus.wbs_dat_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    we_d    = we_q;
    sel_d   = sel_q;
    stb_d   = stb_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rdata_d = rdata_q;
`ifdef WB_MUX_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (bus.wbm_cyc_i && bus.wbm_stb_i) begin
          if (hit) begin
            idx_d   = hit_idx;
            adr_d   = bus.wbm_adr_i;
            wdat_d  = bus.wbm_dat_i;
            we_d    = bus.wbm_we_i;
            sel_d   = bus.wbm_sel_i;
            stb_d   = hit_onehot;
            state_d = S_ACTIVE;
`ifdef WB_MUX_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end else begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end
        end
      end

      S_ACTIVE: begin
        // A dropped cycle wins over any response arriving in the same clock.
        if (!bus.wbm_cyc_i) begin
          stb_d   = '0;
          state_d = S_IDLE;
        end else if (err_sel) begin
          stb_d   = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else if (ack_sel) begin
          stb_d   = '0;
          ack_d   = 1'b1;
          state_d = S_RESP;
          if (!we_q) begin
            rdata_d = rdata_sel;
          end
        end
`ifdef WB_MUX_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          stb_d     = '0;
          err_d     = 1'b1;
          timeout_d = 1'b1;
          cnt_d     = cnt_q + CNT_W'(1);
          state_d   = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        stb_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      adr_q   <= '0;
      wdat_q  <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      stb_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the pre-edge value of its _d.
      state_q <= state_d;
      idx_q   <= idx_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      stb_q   <= stb_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef WB_MUX_TIMEOUT_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_timeout = timeout_q;
`else
  assign o_timeout = 1'b0;
`endif

  assign bus.wbm_dat_o = rdata_q;
  assign bus.wbm_ack_o = ack_q;
  assign bus.wbm_err_o = err_q;

  assign bus.wbs_adr_o = adr_q;
  assign bus.wbs_dat_o = wdat_q;
  assign bus.wbs_we_o  = we_q;
  assign bus.wbs_sel_o = sel_q;
  assign bus.wbs_stb_o = stb_q;
  assign bus.wbs_cyc_o = stb_q;

  assign o_busy    = (state_q != S_IDLE);
  assign o_sel_idx = idx_q;

endmodule

// File: tb/tb_wb_mux_n.sv
// Self-checking bench for wb_mux_n: directed scenarios plus randomized transactions against a decode/response model.
// Exercises the timeout path when WB_MUX_TIMEOUT_EN is defined.
module tb_wb_mux_n;
  localparam int NS = 4;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 8;

  logic              i_clk = 1'b0;
  logic              i_rst_n;
  logic [NS*AW-1:0]  slv_addr;
  logic [NS*AW-1:0]  slv_mask;
  logic              o_busy;
  logic [1:0]        o_sel_idx;
  logic              o_timeout;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  logic [AW-1:0] m_addr [NS];
  logic [AW-1:0] m_mask [NS];
  logic [DW-1:0] m_rdata;
  int            m_idx;
  logic          m_timeout;

  wb_mux_n_if #(.NUM_SLAVES(NS), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SEL_WIDTH(SW)) bus ();

  wb_mux_n #(
    .NUM_SLAVES    (NS),
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .SEL_WIDTH     (SW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .bus       (bus),
    .i_slv_addr(slv_addr),
    .i_slv_mask(slv_mask),
    .o_busy    (o_busy),
    .o_sel_idx (o_sel_idx),
    .o_timeout (o_timeout)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // First slave k (ascending) whose masked prefix equals the masked address.
  function automatic int model_decode(input logic [AW-1:0] a);
    for (int k = 0; k < NS; k++) begin
      if ((a & m_mask[k]) == (m_addr[k] & m_mask[k])) return k;
    end
    return -1;
  endfunction

  task automatic program_map();
    for (int k = 0; k < NS; k++) begin
      slv_addr[k*AW +: AW] = m_addr[k];
      slv_mask[k*AW +: AW] = m_mask[k];
    end
  endtask

  task automatic default_map();
    for (int k = 0; k < NS; k++) begin
      m_addr[k] = AW'(k * 32'h100);
      m_mask[k] = 32'hFFFF_FF00;
    end
    program_map();
  endtask

  task automatic quiet_slaves();
    bus.wbs_ack_i = '0;
    bus.wbs_err_i = '0;
    bus.wbs_dat_i = '0;
  endtask

  task automatic drop_master();
    bus.wbm_cyc_i = 1'b0;
    bus.wbm_stb_i = 1'b0;
  endtask

  task automatic drive_master(input logic [AW-1:0] a, input logic we, input logic [DW-1:0] wd,
                              input logic [SW-1:0] sel);
    bus.wbm_adr_i = a;
    bus.wbm_dat_i = wd;
    bus.wbm_we_i  = we;
    bus.wbm_sel_i = sel;
    bus.wbm_cyc_i = 1'b1;
    bus.wbm_stb_i = 1'b1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ack"},  64'(bus.wbm_ack_o), 64'(0));
    check({tag, "_err"},  64'(bus.wbm_err_o), 64'(0));
    check({tag, "_stb"},  64'(bus.wbs_stb_o), 64'(0));
    check({tag, "_cyc"},  64'(bus.wbs_cyc_o), 64'(0));
    check({tag, "_busy"}, 64'(o_busy),        64'(0));
    check({tag, "_idx"},  64'(o_sel_idx),     64'(m_idx));
    check({tag, "_rdat"}, 64'(bus.wbm_dat_o), 64'(m_rdata));
    check({tag, "_tout"}, 64'(o_timeout),     64'(m_timeout));
  endtask

  // Called at a negedge; returns at the negedge of the first IDLE cycle after the response.
  // kind: 0 = slave ack, 1 = slave err, 2 = ack and err together.
  task automatic run_txn(input string tag, input logic [AW-1:0] a, input logic we,
                         input logic [DW-1:0] wd, input logic [SW-1:0] sel,
                         input int waits, input int kind, input logic [DW-1:0] rd);
    int            k;
    logic [NS-1:0] oh;
    logic [NS-1:0] noise;
    k  = model_decode(a);
    oh = '0;
    drive_master(a, we, wd, sel);
    quiet_slaves();
    @(negedge i_clk);
    if (k < 0) begin
      check({tag, "_decerr"},  64'(bus.wbm_err_o), 64'(1));
      check({tag, "_decack"},  64'(bus.wbm_ack_o), 64'(0));
      check({tag, "_decstb"},  64'(bus.wbs_stb_o), 64'(0));
      check({tag, "_decbusy"}, 64'(o_busy),        64'(1));
    end else begin
      oh[k] = 1'b1;
      check({tag, "_stb"},  64'(bus.wbs_stb_o), 64'(oh));
      check({tag, "_cyc"},  64'(bus.wbs_cyc_o), 64'(oh));
      check({tag, "_adr"},  64'(bus.wbs_adr_o), 64'(a));
      check({tag, "_wdat"}, 64'(bus.wbs_dat_o), 64'(wd));
      check({tag, "_we"},   64'(bus.wbs_we_o),  64'(we));
      check({tag, "_sel"},  64'(bus.wbs_sel_o), 64'(sel));
      for (int w = 0; w < waits; w++) begin
        noise = NS'($urandom);
        bus.wbs_ack_i = noise & ~oh;
        noise = NS'($urandom);
        bus.wbs_err_i = noise & ~oh;
        bus.wbs_dat_i = {$urandom, $urandom, $urandom, $urandom};
        @(negedge i_clk);
        check({tag, "_waitresp"}, 64'({bus.wbm_ack_o, bus.wbm_err_o}), 64'(0));
        check({tag, "_waitstb"},  64'(bus.wbs_stb_o), 64'(oh));
      end
      noise = NS'($urandom);
      bus.wbs_ack_i = (noise & ~oh) | ((kind != 1) ? oh : '0);
      noise = NS'($urandom);
      bus.wbs_err_i = (noise & ~oh) | ((kind != 0) ? oh : '0);
      bus.wbs_dat_i = {$urandom, $urandom, $urandom, $urandom};
      bus.wbs_dat_i[k*DW +: DW] = rd;
      @(negedge i_clk);
      quiet_slaves();
      if (kind == 0 && !we) m_rdata = rd;
      m_idx = k;
      check({tag, "_ack"},     64'(bus.wbm_ack_o), 64'((kind == 0) ? 1 : 0));
      check({tag, "_err"},     64'(bus.wbm_err_o), 64'((kind != 0) ? 1 : 0));
      check({tag, "_respstb"}, 64'(bus.wbs_stb_o), 64'(0));
      check({tag, "_idx"},     64'(o_sel_idx),     64'(m_idx));
      check({tag, "_rdat"},    64'(bus.wbm_dat_o), 64'(m_rdata));
    end
    drop_master();
    @(negedge i_clk);
    check_idle({tag, "_post"});
  endtask

  initial begin
    logic [AW-1:0] ra;
    logic [DW-1:0] rw;
    logic [DW-1:0] rr;
    i_rst_n   = 1'b0;
    m_rdata   = '0;
    m_idx     = 0;
    m_timeout = 1'b0;
    bus.wbm_adr_i = '0;
    bus.wbm_dat_i = '0;
    bus.wbm_we_i  = 1'b0;
    bus.wbm_sel_i = '0;
    drop_master();
    quiet_slaves();
    default_map();

    #2;
    check_idle("reset");
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    check_idle("after_reset");

    // Write to slave1, zero-wait ack
    run_txn("wr_s1", 32'h0000_0104, 1'b1, 32'hA5A5_0001, 4'hF, 0, 0, 32'h1234_5678);
    // Read from slave2 with three wait states; back-to-back with the write
    run_txn("rd_s2", 32'h0000_0208, 1'b0, 32'h0, 4'hF, 3, 0, 32'hDEAD_BEEF);
    check("rd_s2_sel_idx", 64'(o_sel_idx), 64'(2));
    // Unmapped address
    run_txn("unmapped", 32'h0000_0400, 1'b0, 32'h0, 4'hF, 0, 0, 32'h0);
    // Slave error, and simultaneous ack+err
    run_txn("slv_err", 32'h0000_0310, 1'b0, 32'h0, 4'h3, 1, 1, 32'h5555_AAAA);
    run_txn("ack_err", 32'h0000_0020, 1'b0, 32'h0, 4'hF, 0, 2, 32'h6666_7777);

    // Overlap: slave3 aliases slave0's window; the lower index must win
    m_addr[3] = 32'h0000_0000;
    m_mask[3] = 32'hFFFF_FE00;
    program_map();
    run_txn("overlap", 32'h0000_0010, 1'b0, 32'h0, 4'hF, 0, 0, 32'h0BAD_F00D);
    check("overlap_idx", 64'(o_sel_idx), 64'(0));
    default_map();

    // Abort: master drops cyc after two ACTIVE cycles
    drive_master(32'h0000_0300, 1'b0, 32'h0, 4'hF);
    @(negedge i_clk);
    check("abort_stb1", 64'(bus.wbs_stb_o), 64'(4'b1000));
    @(negedge i_clk);
    check("abort_stb2", 64'(bus.wbs_stb_o), 64'(4'b1000));
    drop_master();
    m_idx = 3;
    @(negedge i_clk);
    check_idle("abort");
    @(negedge i_clk);
    check_idle("abort_late");

    // Randomized transactions over mapped and unmapped space
    for (int n = 0; n < 40; n++) begin
      ra = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 32'h4FF));
      rw = $urandom;
      rr = $urandom;
      run_txn("rand", ra, 1'($urandom), rw, SW'($urandom), $urandom_range(0, 3),
              ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 2)) : 0, rr);
    end

`ifdef WB_MUX_TIMEOUT_EN
    // Slave0 never answers: err after TO ACTIVE cycles, sticky o_timeout
    drive_master(32'h0000_0004, 1'b0, 32'h0, 4'hF);
    @(negedge i_clk);
    for (int c = 1; c <= TO; c++) begin
      check("to_wait_err",  64'(bus.wbm_err_o), 64'(0));
      check("to_wait_busy", 64'(o_busy),        64'(1));
      check("to_wait_stb",  64'(bus.wbs_stb_o), 64'(4'b0001));
      @(negedge i_clk);
    end
    m_timeout = 1'b1;
    m_idx     = 0;
    check("to_err",  64'(bus.wbm_err_o), 64'(1));
    check("to_flag", 64'(o_timeout),     64'(1));
    check("to_stb",  64'(bus.wbs_stb_o), 64'(0));
    drop_master();
    @(negedge i_clk);
    check_idle("to_post");
    run_txn("to_sticky", 32'h0000_0104, 1'b0, 32'h0, 4'hF, 0, 0, 32'hC0FF_EE00);
`endif

    // Asynchronous reset in the middle of an ACTIVE cycle
    drive_master(32'h0000_0208, 1'b0, 32'h0, 4'hF);
    @(negedge i_clk);
    check("rst_pre_stb", 64'(bus.wbs_stb_o), 64'(4'b0100));
    i_rst_n = 1'b0;
    #1;
    m_rdata   = '0;
    m_idx     = 0;
    m_timeout = 1'b0;
    check_idle("rst_mid");
    drop_master();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    check_idle("rst_release");
    run_txn("recover", 32'h0000_0300, 1'b0, 32'h0, 4'hF, 1, 0, 32'h0F0F_1234);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/wb_mux_n.md
Name: wb_mux_n

Overview:
- Parametrised N-port Wishbone address decoder/mux between one Wishbone master (axis_wb_master) and NUM_SLAVES peripherals (wb_leds, wb_neoPx, future blocks).
- Successor to the fixed two-slave mux. Adds:
  - registered slave selection and responses
  - decode-error response for unmapped addresses
  - abort on master cycle drop
  - optional bus timeout
  - status outputs

Parameters:
NUM_SLAVES, 4, number of slave ports (1..16)
DATA_WIDTH, 32, data bus width in bits
ADDR_WIDTH, 32, address bus width in bits
SEL_WIDTH, DATA_WIDTH/8, byte-select width
TIMEOUT_CYCLES, 255, ACTIVE cycles without ack/err before timeout error (used only with WB_MUX_TIMEOUT_EN)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
wbm_adr_i  in  ADDR_WIDTH  master address
wbm_dat_i  in  DATA_WIDTH  master write data
wbm_dat_o  out  DATA_WIDTH  read data to master (registered)
wbm_we_i  in  1  write enable
wbm_sel_i  in  SEL_WIDTH  byte select
wbm_stb_i  in  1  strobe
wbm_cyc_i  in  1  cycle
wbm_ack_o  out  1  ack pulse to master
wbm_err_o  out  1  error pulse to master
wbs_adr_o  out  ADDR_WIDTH  address broadcast to all slaves
wbs_dat_o  out  DATA_WIDTH  write data broadcast
wbs_we_o  out  1  we broadcast
wbs_sel_o  out  SEL_WIDTH  sel broadcast
wbs_stb_o  out  NUM_SLAVES  per-slave strobe
wbs_cyc_o  out  NUM_SLAVES  per-slave cycle
wbs_dat_i  in  NUM_SLAVES*DATA_WIDTH  read data; slave k at bits [k*DATA_WIDTH +: DATA_WIDTH]
wbs_ack_i  in  NUM_SLAVES  per-slave ack
wbs_err_i  in  NUM_SLAVES  per-slave err
i_slv_addr  in  NUM_SLAVES*ADDR_WIDTH  address prefix per slave
i_slv_mask  in  NUM_SLAVES*ADDR_WIDTH  prefix mask per slave
o_busy  out  1  high in any non-IDLE state
o_sel_idx  out  $clog2(NUM_SLAVES) (min 1)  index of last selected slave
o_timeout  out  1  sticky timeout flag

Behaviour:
- Reset (i_rst_n low, async): state IDLE. All outputs 0: wbm_ack_o, wbm_err_o, wbm_dat_o, wbs_stb_o, wbs_cyc_o, o_busy, o_sel_idx, o_timeout.
- Decode: slave k matches when (wbm_adr_i & mask_k) == (addr_k & mask_k). The lowest matching index wins.
- Broadcast: wbs_adr_o, wbs_dat_o, wbs_we_o, wbs_sel_o are registered copies of the master signals, captured on the IDLE→ACTIVE transition.
- IDLE:
  - wbm_cyc_i & wbm_stb_i & match → latch index, go ACTIVE; wbs_cyc_o[k] and wbs_stb_o[k] high next cycle.
  - No match → go RESP with err.
- ACTIVE: only slave k strobed.
  - wbs_ack_i[k] → capture wbs_dat_i slice k into wbm_dat_o, clear strobes, go RESP with ack.
  - wbs_err_i[k] → clear strobes, go RESP with err.
  - ack and err in the same cycle → err wins.
  - wbm_cyc_i low → abort: clear strobes, go IDLE, no master response.
  - Acks/errs on unselected slaves are ignored.
- RESP: exactly one cycle with wbm_ack_o or wbm_err_o high, then IDLE.
  - wbm_dat_o holds until the next read capture.
- Latency, zero-wait slave: master stb sampled at cycle 0 → slave stb at cycle 1 → master ack at cycle 2.
- Decode error: err at cycle 1.
- Back-to-back: a new request is accepted in the first IDLE cycle after RESP.
- The master must hold stb/cyc until ack/err (classic cycle). No pipelined Wishbone support.

Optional Feature:
WB_MUX_TIMEOUT_EN
- Defined:
  - An ACTIVE-cycle counter clears on entering ACTIVE.
  - When it reaches TIMEOUT_CYCLES without ack/err: clear strobes, go RESP with err, set o_timeout.
  - o_timeout clears only on reset.
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
- Undefined: no counter; ACTIVE waits indefinitely; o_timeout tied 0.

Test Plan:
Common setup: NUM_SLAVES=4; slaves at 0x000, 0x100, 0x200, 0x300; each mask 0xFFFFFF00.
- Write 0x0000_0104 data 0xA5A5_0001, slave1 zero-wait ack → wbs_stb_o=4'b0010 at cycle 1; wbs_dat_o=0xA5A5_0001; wbm_ack_o pulse at cycle 2.
- Read 0x0000_0208, slave2 returns 0xDEAD_BEEF after 3 waits → wbm_dat_o=0xDEAD_BEEF with 1-cycle ack; o_sel_idx=2.
- Access 0x0000_0400 (unmapped) → no wbs_stb_o; wbm_err_o pulse at cycle 1.
- Overlap: slave3 reprogrammed to addr 0x000 mask 0xFFFFFE00; access 0x0000_0010 → slave0 selected, not slave3.
- Master drops cyc after 2 ACTIVE cycles → strobes low next cycle; no ack/err; o_busy=0.
- With WB_MUX_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave0 never acks → err pulse once count reaches 8; o_timeout=1 until i_rst_n low. Assert i_rst_n mid-ACTIVE → all outputs 0 immediately.
